// File: rtl/controller_sseg_counter.sv
// rtl/controller_sseg_counter.sv - Avalon-MM programmable down-counter with stretched overflow pulse
// Optional prescaler feature: define SSEG_COUNTER_PRESCALE_EN
module controller_sseg_counter #(
  parameter int COUNT_WIDTH    = 24,
  parameter int DEFAULT_PERIOD = 49999,
  parameter int OF_STRETCH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        counter_of
);

  localparam int                     SW           = $clog2(OF_STRETCH + 1);
  localparam logic [COUNT_WIDTH-1:0] PERIOD_RST   = COUNT_WIDTH'(DEFAULT_PERIOD);
  localparam logic [SW-1:0]          STRETCH_LOAD = SW'(OF_STRETCH);

  logic                   run_q;
  logic                   cont_q;
  logic [COUNT_WIDTH-1:0] period_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   of_q;
  logic [SW-1:0]          stretch_q;
  logic [7:0]             prescale_q;

  logic wr_en;
  logic wr_ctrl;
  logic wr_period;
  logic wr_count;
  logic wr_status;
  logic reload;
  logic tick;
  logic overflow;
  logic unused_wdata;

  assign wr_en     = chipselect & ~write_n;
  assign wr_ctrl   = wr_en && (address == 2'd0);
  assign wr_period = wr_en && (address == 2'd1);
  assign wr_count  = wr_en && (address == 2'd2);
  assign wr_status = wr_en && (address == 2'd3);

  // Not every writedata bit lands in a register; fold them so none dangles.
  assign unused_wdata = ^writedata;

  // A COUNT write, or a RUN 0->1 transition, restarts the interval from PERIOD.
  assign reload = wr_count | (wr_ctrl & writedata[0] & ~run_q);

  // A restart landing on the same cycle as an overflow suppresses the overflow.
  assign overflow = tick && (count_q == '0) && !wr_count;

  assign counter_of = (stretch_q != '0);

`ifdef SSEG_COUNTER_PRESCALE_EN
  logic [7:0] presc_cnt_q;

  assign tick = run_q && (presc_cnt_q == prescale_q);

  // Prescale divider: counts RUN cycles and wraps on the programmed terminal value.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale_q  <= 8'd0;
      presc_cnt_q <= 8'd0;
    end else begin
      if (wr_ctrl) prescale_q <= writedata[15:8];
      if (reload) begin
        presc_cnt_q <= 8'd0;
      end else if (run_q) begin
        presc_cnt_q <= tick ? 8'd0 : presc_cnt_q + 8'd1;
      end
    end
  end
`else
  assign prescale_q = 8'd0;
  assign tick       = run_q;
`endif

  // Control, period and status registers; one-shot overflow drops RUN last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      run_q    <= 1'b0;
      cont_q   <= 1'b0;
      period_q <= PERIOD_RST;
      of_q     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        run_q  <= writedata[0];
        cont_q <= writedata[1];
      end
      if (overflow && !cont_q) run_q <= 1'b0;
      if (wr_period) period_q <= writedata[COUNT_WIDTH-1:0];
      if (overflow) begin
        of_q <= 1'b1;
      end else if (wr_status) begin
        of_q <= 1'b0;
      end
    end
  end

  // Down-counter: decrement on each tick, reload from PERIOD on zero or restart.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= PERIOD_RST;
    end else if (reload) begin
      count_q <= period_q;
    end else if (tick) begin
      count_q <= (count_q == '0) ? period_q : count_q - COUNT_WIDTH'(1);
    end
  end

  // Pulse stretcher keeps counter_of high for OF_STRETCH cycles after each overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      stretch_q <= '0;
    end else if (overflow) begin
      stretch_q <= STRETCH_LOAD;
    end else if (stretch_q != '0) begin
      stretch_q <= stretch_q - SW'(1);
    end
  end

  // Registered read mux, refreshed every cycle from address.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'd0;
    end else begin
      case (address)
        2'd0:    readdata <= {16'd0, prescale_q, 6'd0, cont_q, run_q};
        2'd1:    readdata <= 32'(period_q);
        2'd2:    readdata <= 32'(count_q);
        default: readdata <= {30'd0, run_q, of_q};
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sseg_counter.sv
// tb/tb_controller_sseg_counter.sv - randomized self-checking bench for controller_sseg_counter
`timescale 1ns/1ps
module tb_controller_sseg_counter;

  localparam int OF_STRETCH = 2;
  localparam int DEF_PERIOD = 49999;
`ifdef SSEG_COUNTER_PRESCALE_EN
  localparam bit HAS_PS = 1'b1;
`else
  localparam bit HAS_PS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        counter_of;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int rise_q[$];
  int width_q[$];
  int hi_len       = 0;
  logic prev_of    = 1'b0;

  controller_sseg_counter #(
    .COUNT_WIDTH   (24),
    .DEFAULT_PERIOD(DEF_PERIOD),
    .OF_STRETCH    (OF_STRETCH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .counter_of(counter_of)
  );

  always #5 clk = ~clk;

  // Edge index of the most recent rising clock edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Record rise times and high widths of counter_of, sampled mid-cycle.
  always @(negedge clk) begin
    if (counter_of && !prev_of) rise_q.push_back(cyc);
    if (counter_of) begin
      hi_len = hi_len + 1;
    end else if (hi_len > 0) begin
      width_q.push_back(hi_len);
      hi_len = 0;
    end
    prev_of = counter_of;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, output int t);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    t          = cyc;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk);
    #1;
    d = readdata;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    logic [31:0] d;
    bus_read(2'd0, d); check({pfx, "_control"}, d, 32'd0);
    bus_read(2'd1, d); check({pfx, "_period"},  d, DEF_PERIOD);
    bus_read(2'd2, d); check({pfx, "_count"},   d, DEF_PERIOD);
    bus_read(2'd3, d); check({pfx, "_status"},  d, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int t, t0, ts, tr, lows;
    bit seen;

    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
    idle(3);
    check("rst_readdata", readdata, 32'd0);
    check("rst_counter_of", {31'd0, counter_of}, 32'd0);
    reset = 1'b0;
    check_reset_values("rst");

    // Randomized continuous runs: overflow times, pulse widths, frozen count.
    for (int k = 0; k < 4; k++) begin
      int p, ps, ival, nrise, nt;
      p    = $urandom_range(2, 20);
      ps   = HAS_PS ? $urandom_range(0, 3) : 0;
      ival = (p + 1) * (ps + 1);
      bus_write(2'd1, p, t);
      bus_write(2'd3, 32'd0, t);
      rise_q.delete();
      width_q.delete();
      bus_write(2'd0, (ps << 8) | 3, t0);
      idle(2 * ival);
      bus_read(2'd3, d);
      check($sformatf("t%0d_status_run", k), d, 32'h3);
      idle($urandom_range(ival, 2 * ival));
      bus_write(2'd0, (ps << 8) | 2, ts);
      idle(OF_STRETCH + 2);
      nrise = (ts - t0) / ival;
      check($sformatf("t%0d_nrise", k), rise_q.size(), nrise);
      for (int j = 0; j < nrise && j < rise_q.size(); j++)
        check($sformatf("t%0d_rise%0d", k, j), rise_q[j], t0 + (j + 1) * ival);
      for (int j = 0; j < width_q.size(); j++)
        check($sformatf("t%0d_width%0d", k, j), width_q[j], OF_STRETCH);
      nt = (ts - t0) / (ps + 1);
      bus_read(2'd2, d);
      check($sformatf("t%0d_count_frozen", k), d, p - (nt % (p + 1)));
      bus_read(2'd3, d);
      check($sformatf("t%0d_status_stop", k), d, 32'h1);
      bus_read(2'd0, d);
      check($sformatf("t%0d_control", k), d, HAS_PS ? ((ps << 8) | 2) : 2);
    end

    // One-shot PERIOD=5: one overflow six cycles after start.
    bus_write(2'd3, 32'd0, t);
    bus_write(2'd1, 32'd5, t);
    rise_q.delete();
    bus_write(2'd0, 32'h1, t0);
    idle(20);
    check("oneshot_nrise", rise_q.size(), 1);
    check("oneshot_time", rise_q.size() > 0 ? rise_q[0] : -1, t0 + 6);
    bus_read(2'd3, d); check("oneshot_status", d, 32'h1);
    bus_read(2'd2, d); check("oneshot_count", d, 32'd5);
    bus_write(2'd3, 32'd0, t);
    bus_read(2'd3, d); check("oneshot_clear", d, 32'h0);

    // PERIOD=0: counter_of held high; status clear loses to simultaneous overflow.
    bus_write(2'd1, 32'd0, t);
    rise_q.delete();
    bus_write(2'd0, 32'h3, t0);
    idle(3);
    lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (!counter_of) lows++;
    end
    check("p0_continuous", lows, 0);
    check("p0_single_edge", rise_q.size(), 1);
    bus_write(2'd3, 32'd0, t);
    bus_read(2'd3, d); check("p0_of_set_wins", d, 32'h3);
    bus_write(2'd0, 32'h0, t);
    idle(3);
    check("p0_of_expired", {31'd0, counter_of}, 32'd0);

    // PERIOD rewrite mid-count takes effect at the next reload; COUNT write restarts.
    bus_write(2'd1, 32'd100, t);
    rise_q.delete();
    bus_write(2'd0, 32'h3, t0);
    idle(30);
    bus_write(2'd1, 32'd10, t);
    idle(120);
    check("pchg_rise0", rise_q.size() > 0 ? rise_q[0] : -1, t0 + 101);
    check("pchg_rise1", rise_q.size() > 1 ? rise_q[1] : -1, t0 + 112);
    check("pchg_rise2", rise_q.size() > 2 ? rise_q[2] : -1, t0 + 123);
    idle($urandom_range(2, 7));
    bus_write(2'd2, 32'd0, tr);
    rise_q.delete();
    idle(15);
    check("restart_rise", rise_q.size() > 0 ? rise_q[0] : -1, tr + 11);

    // Reset while counter_of is stretched returns everything to reset values.
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (counter_of) seen = 1'b1;
    end
    check("midstretch_seen", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("midrst_counter_of", {31'd0, counter_of}, 32'd0);
    check("midrst_readdata", readdata, 32'd0);
    check_reset_values("midrst");

`ifdef SSEG_COUNTER_PRESCALE_EN
    bus_write(2'd1, 32'd2, t);
    rise_q.delete();
    bus_write(2'd0, 32'h0303, t0);
    idle(40);
    check("ps_rise0", rise_q.size() > 0 ? rise_q[0] : -1, t0 + 12);
    check("ps_rise1", rise_q.size() > 1 ? rise_q[1] : -1, t0 + 24);
    check("ps_rise2", rise_q.size() > 2 ? rise_q[2] : -1, t0 + 36);
    bus_read(2'd0, d); check("ps_control", d, 32'h0303);
`else
    bus_write(2'd0, 32'h0303, t);
    bus_read(2'd0, d); check("nops_control", d, 32'h3);
`endif
    bus_write(2'd0, 32'h0, t);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
